// File: rtl/nroot_range_reduce_seq.sv
// Range-reduction front end for the Method-1 n-th root datapath.
// Splits an IEEE754 operand into a mantissa factor and a sqrt count.
module nroot_range_reduce_seq #(
  parameter int EXP_W    = 8,
  parameter int FRAC_W   = 23,
  parameter int BIAS     = 127,
  parameter int FACTOR_W = 24,
  parameter int ROOT_W   = 5,
  parameter int OVER_TH  = 24,
  parameter logic [35:0] SBT_TAB  = {9'd5, 9'd21, 9'd6, 9'd5},
  parameter logic [19:0] ROOT_TAB = {5'd5, 5'd3, 5'd3, 5'd6},
  parameter logic [19:0] KNEG_TAB = {5'd6, 5'd4, 5'd4, 5'd7},
  parameter logic [19:0] KPOS_TAB = {5'd6, 5'd22, 5'd7, 5'd6}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   operand,
  input  logic                    check,
  input  logic                    use_ext,
  input  logic                    ext_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FACTOR_W-1:0]     factor,
  output logic [ROOT_W-1:0]       root,
  output logic                    over,
  output logic                    pos_exp,
  output logic                    neg,
  output logic                    zero,
  output logic                    inf_nan
);

  localparam int OP_W = 1 + EXP_W + FRAC_W;
  localparam int M_W  = FRAC_W + 1;
  localparam int E_W  = EXP_W + 1;
  localparam int S_W  = $clog2(M_W + 1);

  localparam logic signed [E_W-1:0] BIAS_E = E_W'(BIAS);
  localparam logic signed [E_W-1:0] OVER_E = E_W'(OVER_TH);
  localparam logic [E_W-1:0]        M_E    = E_W'(M_W);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    SHIFT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [OP_W-1:0]      op_q, op_d;
  logic                 ck_q, ck_d;
  logic                 ue_q, ue_d;
  logic                 eb_q, eb_d;
  logic signed [E_W-1:0] e_q, e_d;
  logic [1:0]           mode_q, mode_d;
  logic                 pos_q, pos_d;
  logic                 ovr_q, ovr_d;
  logic                 sgn_q, sgn_d;
  logic                 zr_q, zr_d;
  logic                 inf_q, inf_d;
  logic [M_W-1:0]       sh_q, sh_d;
  logic [S_W-1:0]       s_q, s_d;

  logic [FACTOR_W-1:0]  factor_q, factor_d;
  logic [ROOT_W-1:0]    root_q, root_d;
  logic                 over_q, over_d;
  logic                 pos_exp_q, pos_exp_d;
  logic                 neg_q, neg_d;
  logic                 zero_q, zero_d;
  logic                 inf_nan_q, inf_nan_d;

  logic [EXP_W-1:0]      exp_f;
  logic [FRAC_W-1:0]     frac_f;
  logic signed [E_W-1:0] e_w;
  logic [E_W-1:0]        ne_w;
  logic [S_W-1:0]        s_w;
  logic [8:0]            sbt_w;
  logic [4:0]            kneg_w;
  logic [4:0]            kpos_w;
  logic [4:0]            rtab_w;
  logic [4:0]            k_w;
  int                    shamt;
  logic [E_W-1:0]        rsum_w;
  logic [M_W-1:0]        fac_w;

  assign exp_f  = op_q[OP_W-2 -: EXP_W];
  assign frac_f = op_q[FRAC_W-1:0];
  assign e_w    = signed'({1'b0, exp_f}) - BIAS_E;
  assign ne_w   = -e_w;

  // Shift count saturates once the whole mantissa has been pushed out
  always_comb begin
    s_w = '0;
    if (e_w < 0) begin
      if (ne_w > M_E) s_w = S_W'(M_W);
      else            s_w = ne_w[S_W-1:0];
    end
  end

  always_comb begin
    sbt_w  = SBT_TAB[int'(mode_q)*9 +: 9];
    kneg_w = KNEG_TAB[int'(mode_q)*5 +: 5];
    kpos_w = KPOS_TAB[int'(mode_q)*5 +: 5];
    rtab_w = ROOT_TAB[int'(mode_q)*5 +: 5];
    k_w    = pos_q ? kpos_w : kneg_w;
    shamt  = M_W - int'(k_w);
    fac_w  = sh_q >> shamt;
    rsum_w = E_W'(sbt_w) - e_q;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    op_d        = op_q;
    ck_d        = ck_q;
    ue_d        = ue_q;
    eb_d        = eb_q;
    e_d         = e_q;
    mode_d      = mode_q;
    pos_d       = pos_q;
    ovr_d       = ovr_q;
    sgn_d       = sgn_q;
    zr_d        = zr_q;
    inf_d       = inf_q;
    sh_d        = sh_q;
    s_d         = s_q;
    factor_d    = factor_q;
    root_d      = root_q;
    over_d      = over_q;
    pos_exp_d   = pos_exp_q;
    neg_d       = neg_q;
    zero_d      = zero_q;
    inf_nan_d   = inf_nan_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d       = operand;
          ck_d       = check;
          ue_d       = use_ext;
          eb_d       = ext_b;
          in_ready_d = 1'b0;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        e_d     = e_w;
        pos_d   = ~e_w[E_W-1];
        mode_d  = {ue_q ? eb_q : ~e_w[E_W-1], ck_q};
        ovr_d   = (e_w >= OVER_E);
        sgn_d   = op_q[OP_W-1];
        zr_d    = (exp_f == '0);
        inf_d   = (exp_f == '1);
        sh_d    = {1'b1, frac_f};
        s_d     = s_w;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (s_q != '0) begin
          sh_d = sh_q >> 1;
          s_d  = s_q - 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!out_valid_q) begin
          over_d      = ovr_q;
          pos_exp_d   = pos_q;
          neg_d       = sgn_q;
          zero_d      = zr_q;
          inf_nan_d   = inf_q;
          out_valid_d = 1'b1;
          if (zr_q || inf_q) begin
            factor_d = '0;
            root_d   = '0;
          end else if (pos_q) begin
            factor_d = FACTOR_W'(fac_w);
            root_d   = rsum_w[ROOT_W-1:0];
          end else begin
            factor_d = FACTOR_W'(fac_w);
            root_d   = ROOT_W'(rtab_w);
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      op_q        <= '0;
      ck_q        <= 1'b0;
      ue_q        <= 1'b0;
      eb_q        <= 1'b0;
      e_q         <= '0;
      mode_q      <= '0;
      pos_q       <= 1'b0;
      ovr_q       <= 1'b0;
      sgn_q       <= 1'b0;
      zr_q        <= 1'b0;
      inf_q       <= 1'b0;
      sh_q        <= '0;
      s_q         <= '0;
      factor_q    <= '0;
      root_q      <= '0;
      over_q      <= 1'b0;
      pos_exp_q   <= 1'b0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
      inf_nan_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      ck_q        <= ck_d;
      ue_q        <= ue_d;
      eb_q        <= eb_d;
      e_q         <= e_d;
      mode_q      <= mode_d;
      pos_q       <= pos_d;
      ovr_q       <= ovr_d;
      sgn_q       <= sgn_d;
      zr_q        <= zr_d;
      inf_q       <= inf_d;
      sh_q        <= sh_d;
      s_q         <= s_d;
      factor_q    <= factor_d;
      root_q      <= root_d;
      over_q      <= over_d;
      pos_exp_q   <= pos_exp_d;
      neg_q       <= neg_d;
      zero_q      <= zero_d;
      inf_nan_q   <= inf_nan_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign factor    = factor_q;
  assign root      = root_q;
  assign over      = over_q;
  assign pos_exp   = pos_exp_q;
  assign neg       = neg_q;
  assign zero      = zero_q;
  assign inf_nan   = inf_nan_q;

endmodule
